// File: rtl/branch_target_encoder_if.sv
// Write port and request/response handshake of the branch-target encoder.
// The master drives writes and requests; the slave (the encoder) answers.
interface branch_target_encoder_if #(
    parameter int TGT_W   = 8,
    parameter int PTR_W   = 3,
    parameter int STATE_W = 2
);
    logic               wr_en;
    logic [STATE_W-1:0] wr_state;
    logic [PTR_W-1:0]   wr_addr;
    logic [TGT_W-1:0]   wr_target;

    logic               req_valid;
    logic               req_ready;
    logic [STATE_W-1:0] req_state;
    logic [TGT_W-1:0]   req_target;

    logic               rsp_valid;
    logic               rsp_hit;
    logic [PTR_W-1:0]   rsp_addr;

    modport master (
        output wr_en, wr_state, wr_addr, wr_target,
        output req_valid, req_state, req_target,
        input  req_ready, rsp_valid, rsp_hit, rsp_addr
    );

    modport slave (
        input  wr_en, wr_state, wr_addr, wr_target,
        input  req_valid, req_state, req_target,
        output req_ready, rsp_valid, rsp_hit, rsp_addr
    );
endinterface

// File: rtl/branch_target_encoder.sv
// Banked branch-target table with a sequential reverse lookup: given a bank
// and a target PC, return the lowest pointer whose valid entry holds it.
module branch_target_encoder #(
    parameter int TGT_W   = 8,
    parameter int PTR_W   = 3,
    parameter int STATE_W = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    branch_target_encoder_if.slave bus_if
);
    localparam int DEPTH   = 1 << PTR_W;
    localparam int ENTRIES = (1 << STATE_W) * DEPTH;

    typedef enum logic {
        S_IDLE,
        S_SEARCH
    } state_e;

    logic [ENTRIES-1:0] valid_q;
    logic [TGT_W-1:0]   data_q [ENTRIES];

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [STATE_W-1:0] bank_q, bank_d;
    logic [TGT_W-1:0]   tgt_q, tgt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_hit_q, rsp_hit_d;
    logic [PTR_W-1:0]   rsp_addr_q, rsp_addr_d;

    logic [STATE_W+PTR_W-1:0] cmp_sel;
    logic                     cmp_hit;

    // Registered storage: a write in the compare cycle lands after that compare.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                data_q[i] <= '0;
            end
        end else if (bus_if.wr_en) begin
            valid_q[{bus_if.wr_state, bus_if.wr_addr}] <= 1'b1;
            data_q[{bus_if.wr_state, bus_if.wr_addr}]  <= bus_if.wr_target;
        end
    end

    assign cmp_sel = {bank_q, idx_q};
    assign cmp_hit = valid_q[cmp_sel] && (data_q[cmp_sel] == tgt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            bank_q      <= '0;
            tgt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            tgt_q       <= tgt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_addr_q  <= rsp_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        tgt_d       = tgt_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit_q;
        rsp_addr_d  = rsp_addr_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus_if.req_valid) begin
                    bank_d  = bus_if.req_state;
                    tgt_d   = bus_if.req_target;
                    idx_d   = '0;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (cmp_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_addr_d  = idx_q;
                    state_d     = S_IDLE;
                end else if (idx_q == PTR_W'(DEPTH - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_addr_d  = '0;
                    state_d     = S_IDLE;
                end else begin
                    idx_d = idx_q + PTR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is forced low while reset is held, not just after it is sampled.
    assign bus_if.req_ready = (state_q == S_IDLE) && !rst_i;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_hit   = rsp_hit_q;
    assign bus_if.rsp_addr  = rsp_addr_q;
endmodule
